vga_test_pattern: RTL and testbench

VGA_TEST_PATTERN -- requirements
Module: vga_test_pattern

---
 rtl/vga_test_pattern.sv | 119 +++++++++++
 tb/tb_vga_test_pattern.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_test_pattern.sv
// VGA test pattern generator: bars, checker and scrolling bars with frame-synced mode switch.
// Define VGA_TEST_PATTERN_SCROLL_EN to make mode 3 scroll; otherwise mode 3 renders as mode 0.
module vga_test_pattern #(
  parameter int H_VISIBLE   = 640,
  parameter int V_VISIBLE   = 480,
  parameter int COLOR_BITS  = 4,
  parameter int NUM_BARS    = 8,
  parameter int CHECK_SHIFT = 5,
  parameter int SCROLL_STEP = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            column,
  input  logic [9:0]            row,
  input  logic [1:0]            mode_in,
  input  logic                  mode_req,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  output logic [1:0]            mode,
  output logic [15:0]           frame_count
);

  localparam int BAR_W = H_VISIBLE / NUM_BARS;
  localparam int BAR_H = V_VISIBLE / NUM_BARS;

  logic [COLOR_BITS-1:0] r_red;
  logic [COLOR_BITS-1:0] r_green;
  logic [COLOR_BITS-1:0] r_blue;
  logic [1:0]            r_mode;
  logic [1:0]            r_pend;
  logic                  r_pend_v;
  logic [15:0]           r_frame;

  logic       w_tick;
  logic       w_visible;
  logic       w_chk;
  logic [2:0] w_vbar;
  logic [2:0] w_hbar;
  logic [2:0] w_idx;

  assign w_tick    = (row == 10'(V_VISIBLE)) && (column == 10'd0);
  assign w_visible = (column < 10'(H_VISIBLE)) && (row < 10'(V_VISIBLE));
  assign w_chk     = column[CHECK_SHIFT] ^ row[CHECK_SHIFT];
  assign w_vbar    = 3'(column / 10'(BAR_W));
  assign w_hbar    = 3'(row / 10'(BAR_H));

`ifdef VGA_TEST_PATTERN_SCROLL_EN
  logic [9:0]  r_scroll;
  logic [10:0] w_hsum;
  logic [10:0] w_hpos;
  logic [10:0] w_snext;
  logic [2:0]  w_sbar;

  // 11-bit sum cannot overflow; one subtract suffices for visible columns
  assign w_hsum  = {1'b0, column} + {1'b0, r_scroll};
  assign w_hpos  = (w_hsum >= 11'(H_VISIBLE)) ?
                   w_hsum - 11'(H_VISIBLE) : w_hsum;
  assign w_sbar  = 3'(w_hpos / 11'(BAR_W));
  assign w_snext = {1'b0, r_scroll} + 11'(SCROLL_STEP);
`endif

  always_comb begin
    w_idx = 3'd0;
    unique case (r_mode)
      2'd0: w_idx = w_vbar;
      2'd1: w_idx = w_hbar;
      2'd2: w_idx = {3{w_chk}};
`ifdef VGA_TEST_PATTERN_SCROLL_EN
      2'd3: w_idx = w_sbar;
`else
      2'd3: w_idx = w_vbar;
`endif
      default: w_idx = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
      r_mode   <= 2'd0;
      r_pend   <= 2'd0;
      r_pend_v <= 1'b0;
      r_frame  <= 16'd0;
`ifdef VGA_TEST_PATTERN_SCROLL_EN
      r_scroll <= 10'd0;
`endif
    end else begin
      r_red   <= {COLOR_BITS{w_idx[0] & w_visible}};
      r_green <= {COLOR_BITS{w_idx[1] & w_visible}};
      r_blue  <= {COLOR_BITS{w_idx[2] & w_visible}};
      if (w_tick) begin
        r_frame  <= r_frame + 16'd1;
        r_pend_v <= 1'b0;
        // a request landing on the tick itself wins over the pending one
        if (mode_req)
          r_mode <= mode_in;
        else if (r_pend_v)
          r_mode <= r_pend;
`ifdef VGA_TEST_PATTERN_SCROLL_EN
        r_scroll <= (w_snext >= 11'(H_VISIBLE)) ?
                    10'(w_snext - 11'(H_VISIBLE)) : w_snext[9:0];
`endif
      end else if (mode_req) begin
        r_pend   <= mode_in;
        r_pend_v <= 1'b1;
      end
    end
  end

  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign mode        = r_mode;
  assign frame_count = r_frame;

endmodule

// File: tb/tb_vga_test_pattern.sv
// Scoreboard bench for vga_test_pattern: directed scenarios plus random pixels.
module tb_vga_test_pattern;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int NB = 8;
  localparam int CS = 5;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  column;
  logic [9:0]  row;
  logic [1:0]  mode_in;
  logic        mode_req;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic [1:0]  mode;
  logic [15:0] frame_count;

  vga_test_pattern dut (
    .clk(clk), .reset(reset), .column(column), .row(row),
    .mode_in(mode_in), .mode_req(mode_req),
    .red(red), .green(green), .blue(blue),
    .mode(mode), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic [1:0]  md;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  int m_mode = 0;
  int m_pend = 0;
  int m_pv = 0;
  int m_fc = 0;
  int m_scroll = 0;

  function automatic logic [11:0] ref_rgb(int c, int r, int md, int scr);
    int idx;
    if (c >= H || r >= V) return 12'h000;
    case (md)
      0: idx = c / (H / NB);
      1: idx = r / (V / NB);
      2: idx = (((c >> CS) ^ (r >> CS)) & 1) ? 7 : 0;
      default: begin
`ifdef VGA_TEST_PATTERN_SCROLL_EN
        idx = ((c + scr) % H) / (H / NB);
`else
        idx = c / (H / NB);
`endif
      end
    endcase
    return {(idx & 1) ? 4'hF : 4'h0,
            (idx & 2) ? 4'hF : 4'h0,
            (idx & 4) ? 4'hF : 4'h0};
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit rst, int c, int r, bit req, int mi);
    exp_t e;
    reset    = rst;
    column   = 10'(c);
    row      = 10'(r);
    mode_req = req;
    mode_in  = 2'(mi);
    e.rgb = rst ? 12'h000 : ref_rgb(c, r, m_mode, m_scroll);
    if (rst) begin
      m_mode = 0; m_pend = 0; m_pv = 0; m_fc = 0; m_scroll = 0;
    end else if (r == V && c == 0) begin
      m_fc = (m_fc + 1) % 65536;
      m_scroll = (m_scroll + SS) % H;
      if (req) m_mode = mi;
      else if (m_pv != 0) m_mode = m_pend;
      m_pv = 0;
    end else if (req) begin
      m_pend = mi;
      m_pv = 1;
    end
    e.md = 2'(m_mode);
    e.fc = 16'(m_fc);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic tick();
    step(0, 0, V, 0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("rgb", {red, green, blue}, e.rgb);
      chk("mode", mode, e.md);
      chk("frame_count", frame_count, e.fc);
    end
  end

  initial begin
    reset = 1'b1; column = '0; row = '0; mode_in = '0; mode_req = 1'b0;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 100, 10, 1, 2);
    // mode 0 bar edges and blanking
    step(0, 0, 10, 0, 0);
    step(0, 79, 10, 0, 0);
    step(0, 80, 10, 0, 0);
    step(0, 639, 10, 0, 0);
    step(0, 640, 10, 0, 0);
    // pending switch to checker, applied only at the tick
    step(0, 5, 100, 1, 2);
    step(0, 200, 300, 0, 0);
    step(0, 1, V, 0, 0);
    tick();
    step(0, 32, 0, 0, 0);
    step(0, 32, 32, 0, 0);
    step(0, 700, 32, 0, 0);
    // last request wins
    step(0, 10, 10, 1, 1);
    step(0, 10, 200, 1, 3);
    step(0, 100, 200, 0, 0);
    tick();
    step(0, 0, 0, 0, 0);
    // scroll: 40 ticks from a fresh reset
    step(1, 0, 0, 0, 0);
    step(0, 5, 5, 1, 3);
    for (int i = 0; i < 40; i++) tick();
    step(0, 0, 0, 0, 0);
    step(0, 600, 0, 0, 0);
    for (int i = 0; i < 280; i++) tick();
    step(0, 0, 0, 0, 0);
    step(0, 79, 0, 0, 0);
    // hold mode across ticks without a request
    tick();
    step(0, 300, 300, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int c;
      int r;
      if ($urandom_range(0, 19) == 0) begin
        c = 0; r = V;
      end else begin
        c = $urandom_range(0, 700);
        r = $urandom_range(0, 520);
      end
      step(($urandom_range(0, 199) == 0), c, r,
           ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
    end
    // mid-frame reset with mode 2 and count 5, colliding with request and tick
    step(1, 0, 0, 0, 0);
    step(0, 3, 3, 1, 2);
    for (int i = 0; i < 5; i++) tick();
    step(0, 40, 200, 0, 0);
    step(1, 0, V, 1, 3);
    step(0, 100, 10, 0, 0);
    // counter wrap
    for (int i = 0; i < 65535; i++) tick();
    tick();
    step(0, 639, 479, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
